ctrl_seq: RTL and testbench
===========================

CTRL_SEQ -- requirements
Module: ctrl_seq

Interface
REQ-001 The block SHALL have one clock, CLK, and an asynchronous, active-low reset, RST_N; both SHALL precede all other ports.
REQ-002 The ports SHALL be:
- CLK  in  1  clock, rising edge.
- RST_N  in  1  asynchronous active-low reset.
- START  in  1  one-cycle pulse; resumes from halt.
- MEM_DATA  in  16  read data, valid while MEM_ACK=1.
- MEM_ACK  in  1  memory read acknowledge.
- MEM_REQ  out  1  memory read request.
- MEM_ADDR  out  12  read address (=AR).
- PC  out  12  program counter.
- Q_IR  out  16  instruction register.
- DR  out  16  operand register, consumed by the AC stage.
- t  out  3  timing count (SC value) to the AC stage.
- D  out  8  one-hot decode of Q_IR[14:12].
- I  out  1  indirect bit, Q_IR[15].
- HALTED  out  1  halt status.

Function
REQ-003 SC SHALL advance by 1 per cycle unless stalled, cleared, or halted; t SHALL equal SC.
REQ-004 T0: AR SHALL load PC.
REQ-005 T1 (fetch): MEM_REQ=1 with MEM_ADDR=AR; SC SHALL hold until MEM_ACK=1; on that edge Q_IR<=MEM_DATA, PC<=PC+1 (0xFFF wraps to 0x000), SC->2.
REQ-006 T2: D and I SHALL decode from Q_IR; AR<=Q_IR[11:0]; D and I SHALL stay registered until the next T2.
REQ-007 T3, D7=1, I=0 (register-reference): t=3 is the AC execute cycle; SC SHALL clear to 0 next edge. If Q_IR[0]=1 (HLT), HALTED SHALL set on that edge.
REQ-008 T3, D7=1, I=1 (I/O): no side effect; SC SHALL clear.
REQ-009 T3, D7=0, I=1: indirect read at AR with the REQ-005 handshake; AR<=MEM_DATA[11:0] on ACK; then SC->4.
REQ-010 T3, D7=0, I=0: no action; SC->4.
REQ-011 T4, D0/D1/D2 (AND/ADD/LDA): operand read at AR with the handshake; DR<=MEM_DATA on ACK; SC->5.
REQ-012 T5: DR SHALL be stable for the AC stage; SC SHALL clear.
REQ-013 T4, D4 (BUN): PC<=AR; SC SHALL clear.
REQ-014 T4, D3/D5/D6: no side effect (the memory write path belongs to a separate block); SC SHALL clear.
REQ-015 Handshake rules:
- MEM_REQ and MEM_ADDR SHALL remain stable until ACK is sampled.
- MEM_REQ SHALL deassert on the cycle after ACK.
- ACK in the same cycle that REQ rises is legal (zero-wait).
- ACK while MEM_REQ=0 SHALL be ignored.
REQ-016 While HALTED=1, SC SHALL hold 0 and MEM_REQ SHALL stay 0. START SHALL clear HALTED, and the fetch SHALL begin at PC on the next cycle. START while not halted SHALL be ignored.

Reset
REQ-017 On RST_N low, asynchronously: PC, AR, Q_IR, DR, SC, D, I, MEM_REQ and HALTED SHALL be 0, including mid-handshake. Operation SHALL resume at T0 on the first edge after release.

Structure
REQ-018 A shared package SHALL hold the opcode indices D0-D7, the HLT bit mask, the widths 12 and 16, and the timing constants T0-T5; the AC stage SHALL use the same package.
REQ-019 Sub-module: sc_counter, a 3-bit counter with increment, hold and clear controls. All other logic SHALL be in ctrl_seq.

Verification
REQ-020 Reset mid-fetch:
- Stimulus: RST_N low while MEM_REQ=1.
- Response: MEM_REQ=0 immediately; all outputs 0.
- After release: fetch from 0x000.
REQ-021 CLA, zero-wait:
- Stimulus: mem[0x000]=0x7800, ACK zero-wait.
- Response: t sequence 0,1,2,3,0; D=0x80; I=0; PC=0x001.
REQ-022 LDA direct, slow memory:
- Stimulus: mem[0]=0x2005, mem[5]=0x1234, ACK delayed 2 cycles on every read.
- Response: t holds 1 for 3 cycles, then holds 4 for 3 cycles; t=5 with DR=0x1234; then t=0.
REQ-023 ADD indirect:
- Stimulus: mem[0]=0x9010, mem[0x010]=0x0020, mem[0x020]=0xBEEF.
- Response: AR=0x020 after T3; DR=0xBEEF at t=5.
REQ-024 BUN and PC wrap:
- BUN: 0x4123 -> PC=0x123 after T4; next MEM_ADDR=0x123.
- Wrap: fetch at 0xFFF -> PC=0x000.
REQ-025 HLT and resume:
- Stimulus: 0x7001, then no START for 10 cycles.
- Response: HALTED=1; t=0 and MEM_REQ=0 for those 10 cycles.
- Stimulus: START pulse.
- Response: HALTED=0; fetch at PC next cycle.

Source files
------------

// File: rtl/ctrl_seq_pkg.sv
// Shared constants for the basic-computer control sequencer and its AC stage.
// Holds the opcode indices (D0..D7), the HLT bit mask, address/data widths,
// the timing-state values T0..T5 and the 3-to-8 opcode decoder.
package ctrl_seq_pkg;
  localparam int AW = 12;
  localparam int DW = 16;

  // Opcode indices into the one-hot D vector
  localparam int D_AND = 0;
  localparam int D_ADD = 1;
  localparam int D_LDA = 2;
  localparam int D_STA = 3;
  localparam int D_BUN = 4;
  localparam int D_BSA = 5;
  localparam int D_ISZ = 6;
  localparam int D_REG = 7;  // register-reference / I/O group

  // Memory-reference opcodes that fetch an operand into DR at T4
  localparam logic [7:0] RD_OPS = 8'((1 << D_AND) | (1 << D_ADD) | (1 << D_LDA));
  // Opcodes whose T4 work lives in another block (write path / AC stage)
  localparam logic [7:0] NOP_OPS = 8'((1 << D_STA) | (1 << D_BSA) | (1 << D_ISZ));

  // Register-reference HLT microoperation bit
  localparam logic [DW-1:0] HLT_MASK = 16'h0001;

  localparam logic [2:0] T0 = 3'd0;
  localparam logic [2:0] T1 = 3'd1;
  localparam logic [2:0] T2 = 3'd2;
  localparam logic [2:0] T3 = 3'd3;
  localparam logic [2:0] T4 = 3'd4;
  localparam logic [2:0] T5 = 3'd5;

  function automatic logic [7:0] dec3(input logic [2:0] op);
    dec3 = 8'd1 << op;
  endfunction
endpackage

// File: rtl/ctrl_seq_sc_counter.sv
// sc_counter: 3-bit sequence counter (SC).
// Ports: CLK, RST_N (async low), i_inc (advance), i_clr (to 0, wins over
// i_inc), o_sc (current count). Holds when neither control is set.
module sc_counter (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       i_inc,
  input  logic       i_clr,
  output logic [2:0] o_sc
);
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N)     o_sc <= '0;
    else if (i_clr) o_sc <= '0;
    else if (i_inc) o_sc <= o_sc + 3'd1;
  end
endmodule

// File: rtl/ctrl_seq.sv
// ctrl_seq: timing/control sequencer for the basic computer.
// Runs fetch (T0-T1), decode (T2), indirect (T3), operand fetch / BUN (T4)
// and hands t, D, I, Q_IR and DR to the AC stage.
// Ports: CLK, RST_N (async low), START (resume from halt),
//   MEM_DATA/MEM_ACK/MEM_REQ/MEM_ADDR read handshake, PC, Q_IR, DR, t (=SC),
//   D (one-hot opcode), I (indirect bit), HALTED.
module ctrl_seq
  import ctrl_seq_pkg::*;
(
  input  logic          CLK,
  input  logic          RST_N,
  input  logic          START,
  input  logic [DW-1:0] MEM_DATA,
  input  logic          MEM_ACK,
  output logic          MEM_REQ,
  output logic [AW-1:0] MEM_ADDR,
  output logic [AW-1:0] PC,
  output logic [DW-1:0] Q_IR,
  output logic [DW-1:0] DR,
  output logic [2:0]    t,
  output logic [7:0]    D,
  output logic          I,
  output logic          HALTED
);
  logic [AW-1:0] r_pc, r_ar;
  logic [DW-1:0] r_ir, r_dr;
  logic [7:0]    r_d;
  logic          r_i, r_req, r_halted;
  logic [2:0]    w_sc;
  logic          w_inc, w_clr, w_ack, w_rd_op;

  // ACK only counts while a request is outstanding
  assign w_ack   = r_req & MEM_ACK;
  assign w_rd_op = |(r_d & RD_OPS);

  sc_counter u_sc (
    .CLK   (CLK),
    .RST_N (RST_N),
    .i_inc (w_inc),
    .i_clr (w_clr),
    .o_sc  (w_sc)
  );

  always_comb begin
    w_inc = 1'b0;
    w_clr = 1'b0;
    case (w_sc)
      T0: w_inc = !r_halted || START;
      T1: w_inc = w_ack;
      T2: w_inc = 1'b1;
      T3: begin
        if (r_d[D_REG]) w_clr = 1'b1;
        else if (r_i)   w_inc = w_ack;
        else            w_inc = 1'b1;
      end
      T4: begin
        if (w_rd_op) w_inc = w_ack;
        else         w_clr = 1'b1;   // BUN and NOP_OPS finish here
      end
      default: w_clr = 1'b1;         // T5 and unused codes
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_pc     <= '0;
      r_ar     <= '0;
      r_ir     <= '0;
      r_dr     <= '0;
      r_d      <= '0;
      r_i      <= 1'b0;
      r_req    <= 1'b0;
      r_halted <= 1'b0;
    end else begin
      case (w_sc)
        // Request is raised on the T0 edge so a zero-wait ACK closes T1
        // in a single cycle. START folds T0 into the resume edge.
        T0: if (!r_halted || START) begin
          r_halted <= 1'b0;
          r_ar     <= r_pc;
          r_req    <= 1'b1;
        end
        T1: if (w_ack) begin
          r_ir  <= MEM_DATA;
          r_pc  <= r_pc + 12'd1;
          r_req <= 1'b0;
        end
        T2: begin
          r_d  <= dec3(r_ir[14:12]);
          r_i  <= r_ir[15];
          r_ar <= r_ir[AW-1:0];
          if (r_ir[15] && r_ir[14:12] != 3'(D_REG)) r_req <= 1'b1;
        end
        T3: begin
          if (r_d[D_REG]) begin
            if (!r_i && |(r_ir & HLT_MASK)) r_halted <= 1'b1;
          end else if (r_i) begin
            if (w_ack) begin
              r_ar  <= MEM_DATA[AW-1:0];
              r_req <= 1'b0;
            end
          end else if (w_rd_op) begin
            r_req <= 1'b1;
          end
        end
        T4: begin
          if (w_rd_op) begin
            // After an indirect read REQ drops for a cycle, re-raise it here
            if (!r_req) r_req <= 1'b1;
            else if (w_ack) begin
              r_dr  <= MEM_DATA;
              r_req <= 1'b0;
            end
          end else if (r_d[D_BUN]) begin
            r_pc <= r_ar;
          end
        end
        default: ;
      endcase
    end
  end

  assign MEM_REQ  = r_req;
  assign MEM_ADDR = r_ar;
  assign PC       = r_pc;
  assign Q_IR     = r_ir;
  assign DR       = r_dr;
  assign t        = w_sc;
  assign D        = r_d;
  assign I        = r_i;
  assign HALTED   = r_halted;
endmodule

// File: tb/tb_ctrl_seq.sv
module tb_ctrl_seq;
  logic        CLK = 1'b0;
  logic        RST_N;
  logic        START;
  logic [15:0] MEM_DATA;
  logic        MEM_ACK;
  logic        MEM_REQ;
  logic [11:0] MEM_ADDR, PC;
  logic [15:0] Q_IR, DR;
  logic [2:0]  t;
  logic [7:0]  D;
  logic        I, HALTED;

  int checks = 0;
  int failures = 0;

  logic [15:0] mem [4096];
  logic [11:0] exp_addr [$];     // scoreboard of expected read addresses
  int          delay = 0;        // ACK wait cycles after REQ seen
  bit          spur = 1'b0;      // drive ACK while REQ is low
  logic [2:0]  lda_t [10] = '{3'd1, 3'd1, 3'd1, 3'd2, 3'd3, 3'd4, 3'd4, 3'd4, 3'd5, 3'd0};

  ctrl_seq dut (
    .CLK(CLK), .RST_N(RST_N), .START(START), .MEM_DATA(MEM_DATA),
    .MEM_ACK(MEM_ACK), .MEM_REQ(MEM_REQ), .MEM_ADDR(MEM_ADDR), .PC(PC),
    .Q_IR(Q_IR), .DR(DR), .t(t), .D(D), .I(I), .HALTED(HALTED)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic wait_t(input logic [2:0] v, input int max, input string tag);
    int n = 0;
    do begin
      tick();
      n++;
    end while (t !== v && n < max);
    chk(tag, 32'(t), 32'(v));
  endtask

  task automatic reset_assert();
    chk("sb_empty", 32'(exp_addr.size()), 0);
    RST_N = 1'b0;
    tick();
    tick();
  endtask

  // Memory responder: ACK after 'delay' negedges of REQ, checks the address
  initial begin
    int cnt = 0;
    MEM_ACK  = 1'b0;
    MEM_DATA = '0;
    forever begin
      @(negedge CLK);
      if (!RST_N) begin
        MEM_ACK = 1'b0;
        cnt = 0;
      end else if (MEM_REQ) begin
        if (cnt >= delay) begin
          MEM_ACK  = 1'b1;
          MEM_DATA = mem[MEM_ADDR];
          if (exp_addr.size() > 0) chk("rd_addr", 32'(MEM_ADDR), 32'(exp_addr.pop_front()));
        end else begin
          MEM_ACK = 1'b0;
          cnt++;
        end
      end else begin
        MEM_ACK  = spur;
        MEM_DATA = spur ? 16'hDEAD : 16'h0000;
        cnt = 0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    RST_N = 1'b0;
    START = 1'b0;
    for (int a = 0; a < 4096; a++) mem[a] = '0;
    tick();
    tick();
    // reset state
    chk("rst_pc", 32'(PC), 0);
    chk("rst_addr", 32'(MEM_ADDR), 0);
    chk("rst_ir", 32'(Q_IR), 0);
    chk("rst_dr", 32'(DR), 0);
    chk("rst_t", 32'(t), 0);
    chk("rst_d", 32'(D), 0);
    chk("rst_i", 32'(I), 0);
    chk("rst_req", 32'(MEM_REQ), 0);
    chk("rst_halt", 32'(HALTED), 0);

    // reset in the middle of a stalled fetch
    delay = 5;
    RST_N = 1'b1;
    tick();
    chk("mf_t", 32'(t), 1);
    chk("mf_req", 32'(MEM_REQ), 1);
    tick();
    RST_N = 1'b0;
    #1;
    chk("mf_req_async", 32'(MEM_REQ), 0);
    chk("mf_t_async", 32'(t), 0);
    chk("mf_addr_async", 32'(MEM_ADDR), 0);
    tick();

    // CLA, zero-wait
    delay = 0;
    mem[0] = 16'h7800;
    exp_addr.push_back(12'h000);
    RST_N = 1'b1;
    tick();
    chk("cla_t1", 32'(t), 1);
    chk("cla_addr", 32'(MEM_ADDR), 0);
    tick();
    chk("cla_t2", 32'(t), 2);
    chk("cla_ir", 32'(Q_IR), 32'h7800);
    chk("cla_pc", 32'(PC), 1);
    // START while running is ignored
    START = 1'b1;
    tick();
    START = 1'b0;
    chk("cla_t3", 32'(t), 3);
    chk("cla_d", 32'(D), 32'h80);
    chk("cla_i", 32'(I), 0);
    chk("cla_nohalt", 32'(HALTED), 0);
    tick();
    chk("cla_t0", 32'(t), 0);

    // LDA direct, two wait cycles on every read
    reset_assert();
    delay = 2;
    mem[0] = 16'h2005;
    mem[5] = 16'h1234;
    exp_addr.push_back(12'h000);
    exp_addr.push_back(12'h005);
    RST_N = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick();
      chk($sformatf("lda_t%0d", k), 32'(t), 32'(lda_t[k]));
      if (k == 8) chk("lda_dr", 32'(DR), 32'h1234);
    end

    // ADD indirect
    reset_assert();
    delay = 1;
    mem[0]      = 16'h9010;
    mem[12'h10] = 16'h0020;
    mem[12'h20] = 16'hBEEF;
    exp_addr.push_back(12'h000);
    exp_addr.push_back(12'h010);
    exp_addr.push_back(12'h020);
    RST_N = 1'b1;
    wait_t(3'd4, 20, "ind_t4");
    chk("ind_ar", 32'(MEM_ADDR), 32'h020);
    chk("ind_d", 32'(D), 32'h02);
    chk("ind_i", 32'(I), 1);
    wait_t(3'd5, 20, "ind_t5");
    chk("ind_dr", 32'(DR), 32'hBEEF);

    // BUN then HLT then resume
    reset_assert();
    delay = 0;
    mem[0]       = 16'h4123;
    mem[12'h123] = 16'h7001;
    mem[12'h124] = 16'h7800;
    exp_addr.push_back(12'h000);
    exp_addr.push_back(12'h123);
    RST_N = 1'b1;
    wait_t(3'd4, 20, "bun_t4");
    chk("bun_d", 32'(D), 32'h10);
    tick();
    chk("bun_t0", 32'(t), 0);
    chk("bun_pc", 32'(PC), 32'h123);
    tick();
    chk("bun_addr", 32'(MEM_ADDR), 32'h123);
    chk("bun_req", 32'(MEM_REQ), 1);
    n = 0;
    while (HALTED !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    chk("hlt_set", 32'(HALTED), 1);
    chk("hlt_pc", 32'(PC), 32'h124);
    spur = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick();
      chk("hlt_t", 32'(t), 0);
      chk("hlt_req", 32'(MEM_REQ), 0);
    end
    spur = 1'b0;
    tick();
    chk("hlt_ir_kept", 32'(Q_IR), 32'h7001);
    chk("hlt_still", 32'(HALTED), 1);
    exp_addr.push_back(12'h124);
    START = 1'b1;
    tick();
    START = 1'b0;
    chk("res_halt", 32'(HALTED), 0);
    chk("res_req", 32'(MEM_REQ), 1);
    chk("res_addr", 32'(MEM_ADDR), 32'h124);
    wait_t(3'd0, 20, "res_done");

    // PC wrap at 0xFFF
    reset_assert();
    delay = 0;
    mem[0]       = 16'h4FFF;
    mem[12'hFFF] = 16'h7800;
    exp_addr.push_back(12'h000);
    exp_addr.push_back(12'hFFF);
    RST_N = 1'b1;
    wait_t(3'd4, 20, "wrap_t4");
    tick();
    chk("wrap_pc_fff", 32'(PC), 32'hFFF);
    wait_t(3'd2, 20, "wrap_t2");
    chk("wrap_pc", 32'(PC), 0);
    chk("wrap_ir", 32'(Q_IR), 32'h7800);
    chk("sb_final", 32'(exp_addr.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
